// File: rtl/cpu_multicycle.sv
// -----------------------------------------------------------------------------
// cpu_multicycle
//   Multicycle load/store CPU core with a handshaked memory bus.
//   Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH.
//   HALT is terminal until reset. r0 is the program counter.
//
// Parameters
//   WIDTH     register/data/address width (>= 32)
//   N_REG     register count (8 or 16); register index = low log2(N_REG) bits
//   RESET_PC  value of r0 after reset, zero-extended to WIDTH
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   o_addr    bus address, valid while o_rd or o_wr is high
//   o_rd      read request, held until i_ack
//   o_wr      write request, held until i_ack
//   o_wdata   store data, valid with o_wr
//   i_data    read data, sampled in the cycle i_ack is high
//   i_ack     bus acknowledge, completes the pending request
//   o_halted  high while in HALT
//   o_flags   {N, C, Z}, updated only by ADD/SUB
// -----------------------------------------------------------------------------
module cpu_multicycle #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_REG    = 16,
  parameter logic [31:0] RESET_PC = 32'hb000_0000
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] o_addr,
  output logic             o_rd,
  output logic             o_wr,
  output logic [WIDTH-1:0] o_wdata,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ack,
  output logic             o_halted,
  output logic [2:0]       o_flags
);

  localparam int unsigned IW = $clog2(N_REG);

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LDM  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_STR  = 4'd7;

  // r0 starts at the reset PC, everything else at zero.
  localparam logic [WIDTH-1:0] REG_INIT [N_REG] = '{0: WIDTH'(RESET_PC), default: '0};

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [N_REG];
  logic [31:0]      instr;

  // Operands latched in DECODE, so rd==rs and link-through-rs see old values.
  logic [WIDTH-1:0] opa;   // rs
  logic [WIDTH-1:0] opb;   // rt
  logic [WIDTH-1:0] opc;   // rd

  // Pending writeback. A taken jump is expressed as a write of r0.
  logic             res_en;
  logic [IW-1:0]    res_idx;
  logic [WIDTH-1:0] res_val;
  logic             link_en;

  // Instruction fields.
  logic [3:0]    op;
  logic [3:0]    mod;
  logic [IW-1:0] rd_f;
  logic [IW-1:0] rs_f;
  logic [IW-1:0] rt_f;
  logic [15:0]   imm;

  assign op   = instr[31:28];
  assign mod  = instr[27:24];
  assign rd_f = instr[20 +: IW];
  assign rs_f = instr[16 +: IW];
  assign rt_f = instr[12 +: IW];
  assign imm  = instr[15:0];

  // Datapath for EXEC.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] ldi_val;
  logic             cond_ok;

  // NOTE: every always_comb output gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sum_ext = {1'b0, opa} + {1'b0, opb};
    diff    = opa - opb;
    ea      = opa + {{(WIDTH-16){imm[15]}}, imm};

    // LDI.u replaces bits [31:16] only; plain LDI zero-extends.
    ldi_val        = opc;
    ldi_val[31:16] = imm;
    if (!mod[3]) ldi_val = {{(WIDTH-16){1'b0}}, imm};

    cond_ok = 1'b0;
    case (mod[2:0])
      3'd0:    cond_ok = 1'b1;
      3'd1:    cond_ok = o_flags[0];
      3'd2:    cond_ok = !o_flags[0];
      3'd3:    cond_ok = o_flags[1];
      3'd4:    cond_ok = !o_flags[1];
      3'd5:    cond_ok = o_flags[2];
      default: cond_ok = 1'b0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      // NOTE: the register file is small and built from flops; it is reset
      // because r0 must come up holding the reset PC.
      regs     <= REG_INIT;
      instr    <= '0;
      opa      <= '0;
      opb      <= '0;
      opc      <= '0;
      res_en   <= 1'b0;
      res_idx  <= '0;
      res_val  <= '0;
      link_en  <= 1'b0;
      o_addr   <= '0;
      o_rd     <= 1'b0;
      o_wr     <= 1'b0;
      o_wdata  <= '0;
      o_halted <= 1'b0;
      o_flags  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // Right after reset no request is up yet; WB normally raises it.
          if (!o_rd) begin
            o_rd   <= 1'b1;
            o_addr <= regs[0];
          end else if (i_ack) begin
            instr   <= i_data[31:0];
            regs[0] <= regs[0] + WIDTH'(4);
            o_rd    <= 1'b0;
            state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          opa   <= regs[rs_f];
          opb   <= regs[rt_f];
          opc   <= regs[rd_f];
          state <= S_EXEC;
        end

        S_EXEC: begin
          res_en  <= 1'b0;
          res_idx <= rd_f;
          link_en <= 1'b0;
          state   <= S_WB;
          case (op)
            OP_HALT: begin
              o_halted <= 1'b1;
              state    <= S_HALT;
            end
            OP_LDI: begin
              res_en  <= 1'b1;
              res_val <= ldi_val;
            end
            OP_LDM: begin
              res_en <= 1'b1;
              o_rd   <= 1'b1;
              o_addr <= ea;
              state  <= S_MEM;
            end
            OP_STR: begin
              o_wr    <= 1'b1;
              o_addr  <= ea;
              o_wdata <= opc;
              state   <= S_MEM;
            end
            OP_JMP: begin
              if (cond_ok) begin
                res_en  <= 1'b1;
                res_idx <= '0;
                res_val <= opa;
                link_en <= mod[3];
              end
            end
            OP_ADD: begin
              res_en  <= 1'b1;
              res_val <= sum_ext[WIDTH-1:0];
              o_flags <= {sum_ext[WIDTH-1], sum_ext[WIDTH], sum_ext[WIDTH-1:0] == '0};
            end
            OP_SUB: begin
              res_en  <= 1'b1;
              res_val <= diff;
              o_flags <= {diff[WIDTH-1], opa < opb, diff == '0};
            end
            default: ;
          endcase
        end

        S_MEM: begin
          if (i_ack) begin
            if (o_rd) res_val <= i_data;
            o_rd  <= 1'b0;
            o_wr  <= 1'b0;
            state <= S_WB;
          end
        end

        S_WB: begin
          if (res_en)  regs[res_idx]   <= res_val;
          // Link captures the already-incremented PC of the jump itself.
          if (link_en) regs[N_REG-1]   <= regs[0];
          o_rd   <= 1'b1;
          o_addr <= (res_en && res_idx == '0) ? res_val : regs[0];
          state  <= S_FETCH;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
